// File: rtl/gn_axis_arb_pkg.sv
// Shared types and width helpers for the AXI-Stream round-robin arbiter family.
package gn_axis_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/gn_rr_pick.sv
// Combinational round-robin picker: first requester after i_last, wrapping modulo P_NUM_SRC.
module gn_rr_pick
    import gn_axis_arb_pkg::*;
#(
    parameter  int P_NUM_SRC = 4,
    localparam int IDXW      = clog2_min1(P_NUM_SRC)
) (
    input  logic [P_NUM_SRC-1:0] i_req,
    input  logic [IDXW-1:0]      i_last,
    output logic [IDXW-1:0]      o_idx,
    output logic                 o_any
);

    logic [IDXW:0] w_sum;

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        // k = P_NUM_SRC wraps back to i_last itself, so it has lowest priority.
        for (int k = 1; k <= P_NUM_SRC; k++) begin
            w_sum = {1'b0, i_last} + (IDXW+1)'(k);
            if (w_sum >= (IDXW+1)'(P_NUM_SRC)) w_sum = w_sum - (IDXW+1)'(P_NUM_SRC);
            if (!o_any && i_req[w_sum[IDXW-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_sum[IDXW-1:0];
            end
        end
    end

endmodule

// File: rtl/gn_axis_rr_arb.sv
// Round-robin AXI-Stream arbiter: bounded-burst grants into a single registered output stage.
module gn_axis_rr_arb
    import gn_axis_arb_pkg::*;
#(
    parameter  int P_NUM_SRC   = 4,
    parameter  int P_DWIDTH    = 32,
    parameter  int P_MAX_BURST = 4,
    localparam int TIDW        = clog2_min1(P_NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [P_NUM_SRC*P_DWIDTH-1:0] s_axis_tdata,
    input  logic [P_NUM_SRC-1:0]          s_axis_tvalid,
    output logic [P_NUM_SRC-1:0]          s_axis_tready,
    output logic [P_DWIDTH-1:0]           m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [TIDW-1:0]               m_axis_tid
);

    localparam int              CNTW        = clog2_min1(P_MAX_BURST + 1);
    localparam logic [CNTW-1:0] LP_LAST_CNT = CNTW'(P_MAX_BURST - 1);

    arb_state_t          r_state;
    logic [TIDW-1:0]     r_g;
    logic [TIDW-1:0]     r_last;
    logic [CNTW-1:0]     r_cnt;
    logic [P_DWIDTH-1:0] r_dat;
    logic [TIDW-1:0]     r_id;
    logic                r_vld;

    logic [TIDW-1:0]     w_pick;
    logic                w_any;
    logic                w_src_vld;
    logic [P_DWIDTH-1:0] w_src_dat;
    logic                w_rdy;
    logic                w_in_hs;
    logic                w_out_hs;

    gn_rr_pick #(
        .P_NUM_SRC (P_NUM_SRC)
    ) u_pick (
        .i_req  (s_axis_tvalid),
        .i_last (r_last),
        .o_idx  (w_pick),
        .o_any  (w_any)
    );

    always_comb begin
        w_src_dat = '0;
        for (int i = 0; i < P_NUM_SRC; i++) begin
            if (r_g == TIDW'(i)) w_src_dat = s_axis_tdata[i*P_DWIDTH +: P_DWIDTH];
        end
    end

    assign w_src_vld = s_axis_tvalid[r_g];
    // The output register can take a new beat when empty or when it drains this cycle.
    assign w_rdy     = (r_state == ST_BUSY) && (!r_vld || m_axis_tready);
    assign w_in_hs   = w_rdy && w_src_vld;
    assign w_out_hs  = r_vld && m_axis_tready;

    always_comb begin
        s_axis_tready      = '0;
        s_axis_tready[r_g] = w_rdy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_g     <= '0;
            r_last  <= TIDW'(P_NUM_SRC - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_g     <= w_pick;
                        r_last  <= w_pick;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_hs) r_cnt <= r_cnt + CNTW'(1);
                    // Release on a drained source or on the last beat of the burst; a stall holds the grant.
                    if (!w_src_vld || (w_in_hs && (r_cnt == LP_LAST_CNT))) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dat <= '0;
            r_id  <= '0;
            r_vld <= 1'b0;
        end else if (w_in_hs) begin
            r_dat <= w_src_dat;
            r_id  <= r_g;
            r_vld <= 1'b1;
        end else if (w_out_hs) begin
            r_vld <= 1'b0;
        end
    end

    assign m_axis_tdata  = r_dat;
    assign m_axis_tvalid = r_vld;
    assign m_axis_tid    = r_id;

endmodule

// File: tb/tb_gn_axis_rr_arb.sv
// Directed table-driven bench for gn_axis_rr_arb (4 sources, burst 4) plus a 2-source burst-1 instance.
module tb_gn_axis_rr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_tready;
    logic [1:0]      m_tid;

    logic [2*DW-1:0] t1_sdata;
    logic [1:0]      t1_svalid;
    logic [1:0]      t1_sready;
    logic [DW-1:0]   t1_mdata;
    logic            t1_mvalid;
    logic            t1_mready;
    logic [0:0]      t1_mid;

    gn_axis_rr_arb #(.P_NUM_SRC(N), .P_DWIDTH(DW), .P_MAX_BURST(MB)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tid    (m_tid)
    );

    gn_axis_rr_arb #(.P_NUM_SRC(2), .P_DWIDTH(DW), .P_MAX_BURST(1)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (t1_sdata),
        .s_axis_tvalid (t1_svalid),
        .s_axis_tready (t1_sready),
        .m_axis_tdata  (t1_mdata),
        .m_axis_tvalid (t1_mvalid),
        .m_axis_tready (t1_mready),
        .m_axis_tid    (t1_mid)
    );

    typedef struct {
        bit         seg;
        logic [3:0] vld;
        logic       mrdy;
        logic [3:0] e_rdy;
        logic       e_mvld;
        logic [1:0] e_tid;
        logic [31:0] e_dat;
    } vec_t;

    vec_t tbl[$];
    int   sc[N];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat b of source t carries the source number in the top byte and A0+b in the low byte.
    function automatic logic [31:0] beat(input int t, input int b);
        return (32'(t) << 24) | (32'hA0 + 32'(b));
    endfunction

    task automatic add(input bit seg, input logic [3:0] vld, input logic mrdy, input logic [3:0] erdy,
                       input logic emv, input int etid, input int eb);
        vec_t v;
        v.seg = seg; v.vld = vld; v.mrdy = mrdy; v.e_rdy = erdy; v.e_mvld = emv;
        v.e_tid = 2'(etid); v.e_dat = beat(etid, eb);
        tbl.push_back(v);
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = beat(i, sc[i]);
    endtask

    initial begin
        logic [3:0] hs;

        // All four sources continuously valid, bursts of four with one IDLE bubble.
        add(1, 4'b1111, 1, 4'b0000, 0, 0, 0);
        for (int t = 0; t < 4; t++) begin
            add(0, 4'b1111, 1, 4'(1 << t), 0, 0, 0);
            for (int b = 0; b < 3; b++) add(0, 4'b1111, 1, 4'(1 << t), 1, t, b);
            add(0, 4'b1111, 1, 4'b0000, 1, t, 3);
        end
        add(0, 4'b1111, 1, 4'b0001, 0, 0, 0);
        add(0, 4'b1111, 1, 4'b0001, 1, 0, 4);
        add(0, 4'b0000, 1, 4'b0001, 1, 0, 5);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        // Single source 1 sends three beats and releases when it drops tvalid.
        add(1, 4'b0010, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0010, 1, 4'b0010, 0, 0, 0);
        add(0, 4'b0010, 1, 4'b0010, 1, 1, 0);
        add(0, 4'b0010, 1, 4'b0010, 1, 1, 1);
        add(0, 4'b0000, 1, 4'b0010, 1, 1, 2);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        // Late requesters 2 and 3 wait for source 0; source 2 wins next, ahead of 3 and 0.
        add(1, 4'b0001, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0001, 1, 4'b0001, 0, 0, 0);
        add(0, 4'b0101, 1, 4'b0001, 1, 0, 0);
        add(0, 4'b1101, 1, 4'b0001, 1, 0, 1);
        add(0, 4'b1101, 1, 4'b0001, 1, 0, 2);
        add(0, 4'b1101, 1, 4'b0000, 1, 0, 3);
        add(0, 4'b0100, 1, 4'b0100, 0, 0, 0);
        add(0, 4'b0000, 1, 4'b0100, 1, 2, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        // Backpressure: five stalled cycles with one beat held, then the burst resumes.
        add(1, 4'b1000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1000, 1, 4'b1000, 0, 0, 0);
        for (int s = 0; s < 5; s++) add(0, 4'b1000, 0, 4'b0000, 1, 3, 0);
        add(0, 4'b1000, 1, 4'b1000, 1, 3, 0);
        add(0, 4'b1000, 1, 4'b1000, 1, 3, 1);
        add(0, 4'b1000, 1, 4'b1000, 1, 3, 2);
        add(0, 4'b0000, 1, 4'b0000, 1, 3, 3);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        reset = 1'b1;
        s_tvalid = '0; m_tready = 1'b0; s_tdata = '0;
        t1_svalid = '0; t1_mready = 1'b0; t1_sdata = {32'h22, 32'h11};
        for (int i = 0; i < N; i++) sc[i] = 0;

        @(negedge clk);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mdata",  m_tdata,       32'd0);
        chk("rst_mtid",   32'(m_tid),    32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_t1_mvalid", 32'(t1_mvalid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int r = 0; r < tbl.size(); r++) begin
            if (tbl[r].seg) for (int i = 0; i < N; i++) sc[i] = 0;
            s_tvalid = tbl[r].vld;
            m_tready = tbl[r].mrdy;
            drive_data();
            @(negedge clk);
            chk($sformatf("row%0d_tready", r), 32'(s_tready), 32'(tbl[r].e_rdy));
            chk($sformatf("row%0d_mvalid", r), 32'(m_tvalid), 32'(tbl[r].e_mvld));
            if (tbl[r].e_mvld) begin
                chk($sformatf("row%0d_mtid", r),  32'(m_tid), 32'(tbl[r].e_tid));
                chk($sformatf("row%0d_mdata", r), m_tdata,    tbl[r].e_dat);
            end
            hs = s_tvalid & s_tready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) if (hs[i]) sc[i]++;
        end

        // Reset while a beat sits in the output register.
        for (int i = 0; i < N; i++) sc[i] = 0;
        s_tvalid = 4'b0100; m_tready = 1'b0; drive_data();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_pre_mvalid", 32'(m_tvalid), 32'd1);
        chk("midrst_pre_mtid",   32'(m_tid),    32'd2);
        #2 reset = 1'b1;
        #1;
        chk("midrst_mvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_tready", 32'(s_tready), 32'd0);
        chk("midrst_mdata",  m_tdata,       32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        s_tvalid = 4'b0101; m_tready = 1'b1;
        @(negedge clk);
        chk("postrst_idle_tready", 32'(s_tready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("postrst_first_grant", 32'(s_tready), 32'b0001);
        @(posedge clk); #1;
        s_tvalid = '0;
        repeat (3) @(posedge clk);
        #1;

        // Burst limit of one: two sources alternate one beat per grant.
        t1_svalid = 2'b11; t1_mready = 1'b1;
        @(negedge clk);
        chk("b1_idle_tready", 32'(t1_sready), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b1_k%0d_tready", k), 32'(t1_sready), (k % 2 == 1) ? 32'b10 : 32'b01);
            chk($sformatf("b1_k%0d_bubble", k), 32'(t1_mvalid), 32'd0);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("b1_k%0d_idle", k),   32'(t1_sready), 32'd0);
            chk($sformatf("b1_k%0d_mvalid", k), 32'(t1_mvalid), 32'd1);
            chk($sformatf("b1_k%0d_mtid", k),   32'(t1_mid),    32'(k % 2));
            chk($sformatf("b1_k%0d_mdata", k),  t1_mdata,       (k % 2 == 1) ? 32'h22 : 32'h11);
            @(posedge clk); #1;
        end
        t1_svalid = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
